// File: rtl/bus_pkg.sv
// Shared definitions for the memory arbiter: default bus widths, arbiter
// state encoding, port-select encoding and the contention tie-break helper.
package bus_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT_IB = 2'd1,
        ST_GRANT_DB = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IB = 1'b0,
        PORT_DB = 1'b1
    } port_e;

    // Under contention the port that did not win last time is chosen.
    function automatic port_e pick_port(input logic ib_req, input logic db_req,
                                        input port_e last);
        if (ib_req && db_req) begin
            return (last == PORT_DB) ? PORT_IB : PORT_DB;
        end else if (ib_req) begin
            return PORT_IB;
        end else begin
            return PORT_DB;
        end
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Grant-cycle counter: cleared when a grant is issued, counts while a grant
// is held, and flags the TIMEOUT-th held cycle.
module bus_timeout #(
    parameter int TIMEOUT = bus_pkg::DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Count holds at LAST; the arbiter leaves the grant state in that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory bus with
// alternating priority under contention and a per-grant ack timeout.
module mem_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_reset,

    input  logic                i_ib_stb,
    input  logic [ADDR_W-1:0]   i_ib_addr,
    output logic                o_ib_ack,
    output logic                o_ib_err,
    output logic [DATA_W-1:0]   o_ib_rdata,

    input  logic                i_db_stb,
    input  logic                i_db_we,
    input  logic [ADDR_W-1:0]   i_db_addr,
    input  logic [DATA_W-1:0]   i_db_wdata,
    input  logic [DATA_W/8-1:0] i_db_sel,
    output logic                o_db_ack,
    output logic                o_db_err,
    output logic [DATA_W-1:0]   o_db_rdata,

    output logic                o_mem_stb,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_sel,
    input  logic                i_mem_ack,
    input  logic [DATA_W-1:0]   i_mem_rdata,

    output logic                o_busy
);

    arb_state_e state;
    arb_state_e state_nxt;
    port_e      last_grant;
    port_e      grant_port;
    logic       grant_req;
    logic       finish;
    logic       timed_out;
    logic       tmo_clear;
    logic       tmo_en;
    logic       tmo_expired;

    bus_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (i_clk),
        .reset   (i_reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_comb begin
        state_nxt  = state;
        grant_port = pick_port(i_ib_stb, i_db_stb, last_grant);
        grant_req  = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        tmo_clear  = 1'b0;
        tmo_en     = 1'b0;
        o_ib_ack   = 1'b0;
        o_ib_err   = 1'b0;
        o_ib_rdata = '0;
        o_db_ack   = 1'b0;
        o_db_err   = 1'b0;
        o_db_rdata = '0;

        case (state)
            ST_IDLE: begin
                if (i_ib_stb || i_db_stb) begin
                    grant_req = 1'b1;
                    tmo_clear = 1'b1;
                    state_nxt = (grant_port == PORT_IB) ? ST_GRANT_IB : ST_GRANT_DB;
                end
            end
            ST_GRANT_IB, ST_GRANT_DB: begin
                tmo_en    = 1'b1;
                finish    = i_mem_ack || tmo_expired;
                // A real ack in the expiry cycle wins over the timeout.
                timed_out = tmo_expired && !i_mem_ack;
                if (finish) begin
                    state_nxt = ST_IDLE;
                end
                if (state == ST_GRANT_IB) begin
                    o_ib_ack   = finish;
                    o_ib_err   = timed_out;
                    o_ib_rdata = timed_out ? '0 : i_mem_rdata;
                end else begin
                    o_db_ack   = finish;
                    o_db_err   = timed_out;
                    o_db_rdata = timed_out ? '0 : i_mem_rdata;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            last_grant <= PORT_DB;
        end else begin
            state <= state_nxt;
            if (grant_req) begin
                last_grant <= grant_port;
            end
        end
    end

    // Request fields are captured only at the grant decision and held
    // until the transaction completes, independent of the requester.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mem_stb   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_sel   <= '0;
        end else if (grant_req) begin
            o_mem_stb <= 1'b1;
            if (grant_port == PORT_IB) begin
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_ib_addr;
                o_mem_wdata <= '0;
                o_mem_sel   <= '1;
            end else begin
                o_mem_we    <= i_db_we;
                o_mem_addr  <= i_db_addr;
                o_mem_wdata <= i_db_wdata;
                o_mem_sel   <= i_db_sel;
            end
        end else if (finish) begin
            o_mem_stb <= 1'b0;
        end
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued as each
// transaction is set up and matched against every ack the arbiter returns.
module tb_mem_arbiter;

    logic        i_clk;
    logic        i_reset;
    logic        i_ib_stb;
    logic [31:0] i_ib_addr;
    logic        o_ib_ack;
    logic        o_ib_err;
    logic [31:0] o_ib_rdata;
    logic        i_db_stb;
    logic        i_db_we;
    logic [31:0] i_db_addr;
    logic [31:0] i_db_wdata;
    logic [3:0]  i_db_sel;
    logic        o_db_ack;
    logic        o_db_err;
    logic [31:0] o_db_rdata;
    logic        o_mem_stb;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_sel;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_ib_stb    (i_ib_stb),
        .i_ib_addr   (i_ib_addr),
        .o_ib_ack    (o_ib_ack),
        .o_ib_err    (o_ib_err),
        .o_ib_rdata  (o_ib_rdata),
        .i_db_stb    (i_db_stb),
        .i_db_we     (i_db_we),
        .i_db_addr   (i_db_addr),
        .i_db_wdata  (i_db_wdata),
        .i_db_sel    (i_db_sel),
        .o_db_ack    (o_db_ack),
        .o_db_err    (o_db_err),
        .o_db_rdata  (o_db_rdata),
        .o_mem_stb   (o_mem_stb),
        .o_mem_we    (o_mem_we),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_sel   (o_mem_sel),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_busy      (o_busy)
    );

    typedef struct {
        logic        port;   // 0 = IB, 1 = DB
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic port, input logic [31:0] rdata, input logic err);
        exp_t x;
        x.port  = port;
        x.rdata = rdata;
        x.err   = err;
        sbq.push_back(x);
    endtask

    // Leaves the caller at posedge+1 of the first cycle o_mem_stb is high.
    task automatic wait_stb(input string tag);
        int n;
        n = 0;
        while (o_mem_stb !== 1'b1 && n < 30) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check(tag, o_mem_stb, 1'b1);
    endtask

    // Memory answers lat cycles after the first request cycle.
    task automatic serve(input int lat, input logic [31:0] data);
        repeat (lat) @(posedge i_clk);
        #1;
        i_mem_ack   = 1'b1;
        i_mem_rdata = data;
        @(posedge i_clk);
        #1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
    endtask

    // Completion monitor: every ack must match the oldest queued expectation.
    always @(negedge i_clk) begin
        if (!i_reset && (o_ib_ack || o_db_ack)) begin
            check("dual_ack", o_ib_ack & o_db_ack, 1'b0);
            if (sbq.size() == 0) begin
                check("unexpected_ack", {o_db_ack, o_ib_ack}, 2'b00);
            end else begin
                e = sbq.pop_front();
                check("ack_port", o_db_ack, e.port);
                check("ack_rdata", o_db_ack ? o_db_rdata : o_ib_rdata, e.rdata);
                check("ack_err", o_db_ack ? o_db_err : o_ib_err, e.err);
            end
        end
    end

    initial begin
        i_reset     = 1'b1;
        i_ib_stb    = 1'b0;
        i_ib_addr   = '0;
        i_db_stb    = 1'b0;
        i_db_we     = 1'b0;
        i_db_addr   = '0;
        i_db_wdata  = '0;
        i_db_sel    = '0;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_busy", o_busy, 1'b0);
        check("rst_stb", o_mem_stb, 1'b0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_acks", {o_ib_ack, o_ib_err, o_db_ack, o_db_err}, 4'h0);
        i_reset = 1'b0;
        @(posedge i_clk);
        #1;

        // Single instruction fetch
        i_ib_stb  = 1'b1;
        i_ib_addr = 32'h100;
        push(1'b0, 32'hDEADBEEF, 1'b0);
        wait_stb("ib_stb");
        check("ib_addr", o_mem_addr, 32'h100);
        check("ib_we", o_mem_we, 1'b0);
        check("ib_sel", o_mem_sel, 4'hF);
        check("ib_busy", o_busy, 1'b1);
        serve(2, 32'hDEADBEEF);
        i_ib_stb = 1'b0;
        check("ib_stb_drop", o_mem_stb, 1'b0);
        check("ib_idle", o_busy, 1'b0);

        // Data write with partial byte enables, fields held across cycles
        i_db_stb   = 1'b1;
        i_db_we    = 1'b1;
        i_db_addr  = 32'h2000;
        i_db_wdata = 32'h12345678;
        i_db_sel   = 4'b0011;
        push(1'b1, 32'h0000_0042, 1'b0);
        wait_stb("db_stb");
        check("db_we", o_mem_we, 1'b1);
        check("db_addr", o_mem_addr, 32'h2000);
        check("db_wdata", o_mem_wdata, 32'h12345678);
        check("db_sel", o_mem_sel, 4'b0011);
        @(posedge i_clk);
        #1;
        check("db_hold_stb", o_mem_stb, 1'b1);
        check("db_hold_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel},
              {1'b1, 32'h2000, 32'h12345678, 4'b0011});
        serve(0, 32'h0000_0042);
        i_db_stb = 1'b0;
        i_db_we  = 1'b0;

        // Memory never answers: forced error completion on the 8th grant cycle
        i_db_stb  = 1'b1;
        i_db_addr = 32'h3000;
        push(1'b1, 32'h0, 1'b1);
        wait_stb("tmo_stb");
        i_mem_rdata = 32'hBAD0BAD0;
        repeat (6) @(posedge i_clk);
        #1;
        check("tmo_early", o_db_ack, 1'b0);
        check("tmo_early_busy", o_busy, 1'b1);
        @(posedge i_clk);
        #1;
        check("tmo_ack", {o_db_ack, o_db_err}, 2'b11);
        check("tmo_rdata", o_db_rdata, 32'h0);
        i_db_stb = 1'b0;
        @(posedge i_clk);
        #1;
        i_mem_rdata = '0;
        check("tmo_idle", o_busy, 1'b0);
        check("tmo_stb_drop", o_mem_stb, 1'b0);

        // Next request after a timeout is served normally
        i_ib_stb  = 1'b1;
        i_ib_addr = 32'h104;
        push(1'b0, 32'hA5A50001, 1'b0);
        wait_stb("post_tmo_stb");
        check("post_tmo_addr", o_mem_addr, 32'h104);
        serve(1, 32'hA5A50001);
        i_ib_stb = 1'b0;

        // Ack arriving exactly in the timeout cycle is a normal completion
        i_ib_stb  = 1'b1;
        i_ib_addr = 32'h108;
        push(1'b0, 32'hCAFEF00D, 1'b0);
        wait_stb("late_stb");
        serve(7, 32'hCAFEF00D);
        i_ib_stb = 1'b0;

        // Stray ack while idle has no effect
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h77777777;
        @(posedge i_clk);
        #1;
        i_mem_ack   = 1'b0;
        i_mem_rdata = '0;
        check("idle_ack_busy", o_busy, 1'b0);
        check("idle_ack_stb", o_mem_stb, 1'b0);

        // Requester drops stb mid-grant; the transaction still completes
        i_ib_stb  = 1'b1;
        i_ib_addr = 32'h10C;
        push(1'b0, 32'h600DF00D, 1'b0);
        wait_stb("drop_stb");
        i_ib_stb = 1'b0;
        @(posedge i_clk);
        #1;
        check("drop_hold", o_mem_stb, 1'b1);
        serve(1, 32'h600DF00D);

        // Reset in the middle of a data grant
        i_db_stb  = 1'b1;
        i_db_addr = 32'h500;
        wait_stb("rst_mid_stb");
        #3;
        i_reset = 1'b1;
        #1;
        check("rst_mid_stb_low", o_mem_stb, 1'b0);
        check("rst_mid_busy", o_busy, 1'b0);
        check("rst_mid_fields", {o_mem_we, o_mem_addr, o_mem_wdata, o_mem_sel}, 69'h0);
        check("rst_mid_acks", {o_ib_ack, o_ib_err, o_db_ack, o_db_err}, 4'h0);
        @(posedge i_clk);
        #1;
        i_ib_stb   = 1'b1;
        i_ib_addr  = 32'h400;
        i_db_stb   = 1'b1;
        i_db_we    = 1'b1;
        i_db_addr  = 32'h800;
        i_db_wdata = 32'h11;
        i_db_sel   = 4'hF;
        i_reset    = 1'b0;

        // Sustained contention alternates IB, DB, IB, DB starting with IB
        for (int k = 0; k < 4; k++) begin
            logic        port;
            logic [31:0] d;
            port = k[0];
            d    = 32'hC0DE0000 + k;
            push(port, d, 1'b0);
            wait_stb("cont_stb");
            check("cont_addr", o_mem_addr, port ? 32'h800 : 32'h400);
            check("cont_we", o_mem_we, port);
            serve(1, d);
        end
        i_ib_stb = 1'b0;
        i_db_stb = 1'b0;
        i_db_we  = 1'b0;

        repeat (3) @(posedge i_clk);
        #1;
        check("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
